phy_tx_serial: RTL and testbench



---
 rtl/phy_tx_serial.sv | 134 +++++++++++++
 tb/tb_phy_tx_serial.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_serial.sv
// rtl/phy_tx_serial.sv - two-lane serialising transmit datapath with COM fill and alignment preamble
//
// Purpose:
//   Accepts 32-bit words over a valid/ready handshake and stripes them
//   alternately to lane 0 and lane 1, starting with lane 0. Each lane sends
//   its word byte 3 first, MSB first, one byte per 8-cycle slot. Any slot
//   with no data carries COM_CHAR. After reset, ALIGN_BYTES COM bytes are
//   sent before the first word is accepted.
//
// Ports:
//   clock32    in   1   clock, all state updates on the rising edge
//   reset_L    in   1   synchronous active-low reset
//   data_in    in  32   word to transmit
//   valid_in   in   1   data_in valid
//   ready_out  out  1   word accepted on an edge with valid_in && ready_out
//   data_out0  out  1   lane 0 serial bit
//   data_out1  out  1   lane 1 serial bit
//   align_done out  1   alignment preamble has been sent; sticky until reset
//   busy       out  1   a hold register is full or a data byte is being shifted

module phy_tx_serial #(
  parameter logic [7:0]  COM_CHAR    = 8'hBC,
  parameter int unsigned ALIGN_BYTES = 4
) (
  input  logic        clock32,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out0,
  output logic        data_out1,
  output logic        align_done,
  output logic        busy
);

  localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_BYTES - 1);

  logic [2:0]       bit_cnt_q,    bit_cnt_d;
  logic [1:0][7:0]  shift_q,      shift_d;
  logic [1:0][31:0] hold_q,       hold_d;
  logic [1:0]       hold_vld_q,   hold_vld_d;
  logic [1:0][1:0]  idx_q,        idx_d;
  // Set while the shift register of a lane carries a data byte (not COM).
  logic [1:0]       data_byte_q,  data_byte_d;
  logic             lane_sel_q,   lane_sel_d;
  logic [3:0]       align_cnt_q,  align_cnt_d;
  logic             align_done_q, align_done_d;

  logic boundary;
  logic accept;

  assign boundary   = (bit_cnt_q == 3'd7);
  // Decoded from registers only so that it never depends on valid_in.
  assign ready_out  = align_done_q && !hold_vld_q[lane_sel_q];
  assign accept     = valid_in && ready_out;

  assign data_out0  = shift_q[0][7];
  assign data_out1  = shift_q[1][7];
  assign align_done = align_done_q;
  assign busy       = (|hold_vld_q) || (|data_byte_q);

  always_comb begin
    bit_cnt_d    = bit_cnt_q + 3'd1;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    idx_d        = idx_q;
    data_byte_d  = data_byte_q;
    lane_sel_d   = lane_sel_q;
    align_cnt_d  = align_cnt_q;
    align_done_d = align_done_q;

    for (int l = 0; l < 2; l++) begin
      if (boundary) begin
        if (hold_vld_q[l]) begin
          shift_d[l]     = hold_q[l][8*idx_q[l] +: 8];
          idx_d[l]       = idx_q[l] - 2'd1;
          data_byte_d[l] = 1'b1;
          if (idx_q[l] == 2'd0) begin
            hold_vld_d[l] = 1'b0;
          end
        end else begin
          shift_d[l]     = COM_CHAR;
          data_byte_d[l] = 1'b0;
        end
      end else begin
        shift_d[l] = {shift_q[l][6:0], 1'b0};
      end
    end

    // Nothing is accepted before align_done, so lane 0 loads COM on every
    // boundary of the preamble.
    if (boundary && !align_done_q) begin
      align_cnt_d = align_cnt_q + 4'd1;
      if (align_cnt_q == ALIGN_LAST) begin
        align_done_d = 1'b1;
      end
    end

    // An accept only targets an empty hold, so it never collides with the
    // boundary unload above; a same-edge boundary has already chosen COM.
    if (accept) begin
      hold_d[lane_sel_q]     = data_in;
      idx_d[lane_sel_q]      = 2'd3;
      hold_vld_d[lane_sel_q] = 1'b1;
      lane_sel_d             = ~lane_sel_q;
    end
  end

  always_ff @(posedge clock32) begin
    if (!reset_L) begin
      bit_cnt_q    <= 3'd7;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_vld_q   <= '0;
      idx_q        <= '0;
      data_byte_q  <= '0;
      lane_sel_q   <= 1'b0;
      align_cnt_q  <= 4'd0;
      align_done_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      idx_q        <= idx_d;
      data_byte_q  <= data_byte_d;
      lane_sel_q   <= lane_sel_d;
      align_cnt_q  <= align_cnt_d;
      align_done_q <= align_done_d;
    end
  end

endmodule

// File: tb/tb_phy_tx_serial.sv
// tb/tb_phy_tx_serial.sv - directed self-checking bench for phy_tx_serial

module tb_phy_tx_serial;

  logic        clock32 = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out0;
  logic        data_out1;
  logic        align_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Non-reset edges since the last reset; slot k spans edges 8k+1 .. 8k+8.
  int cyc = 0;
  logic [7:0] sr0 = 8'h00;
  logic [7:0] sr1 = 8'h00;
  logic [7:0] lane0_slot [64];
  logic [7:0] lane1_slot [64];

  phy_tx_serial dut (
    .clock32    (clock32),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .align_done (align_done),
    .busy       (busy)
  );

  always #5 clock32 = ~clock32;

  always @(posedge clock32) begin
    if (!reset_L) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clock32) begin
    if (cyc >= 1) begin
      sr0 <= {sr0[6:0], data_out0};
      sr1 <= {sr1[6:0], data_out1};
      if (((cyc - 1) % 8) == 7 && ((cyc - 1) / 8) < 64) begin
        lane0_slot[(cyc - 1) / 8] <= {sr0[6:0], data_out0};
        lane1_slot[(cyc - 1) / 8] <= {sr1[6:0], data_out1};
      end
    end
  end

  task automatic step();
    @(negedge clock32);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (cyc != target) begin
      errors++;
      $display("FAIL wait_cyc: cycle count %0d, required %0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    repeat (5) step();
    checks++;
    if ({data_out0, data_out1, ready_out, align_done, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {data_out0, data_out1, ready_out, align_done, busy});
    end
    reset_L = 1'b1;
    wait_cyc(1);
    checks++;
    if ({data_out0, data_out1} !== 2'b11) begin
      errors++;
      $display("FAIL first_com_bit: got %b, required 11", {data_out0, data_out1});
    end
    wait_cyc(24);
    checks++;
    if ({align_done, ready_out} !== 2'b00) begin
      errors++;
      $display("FAIL align_early: got %b, required 00", {align_done, ready_out});
    end
    wait_cyc(25);
    checks++;
    if ({align_done, ready_out, busy} !== 3'b110) begin
      errors++;
      $display("FAIL align_done_rise: got %b, required 110", {align_done, ready_out, busy});
    end
    wait_cyc(33);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (lane0_slot[s] !== 8'hBC || lane1_slot[s] !== 8'hBC) begin
        errors++;
        $display("FAIL preamble slot %0d: got %h/%h, required bc/bc", s, lane0_slot[s], lane1_slot[s]);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp0 [6];
    exp0 = '{8'hBC, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hBC};
    wait_cyc(35);
    valid_in = 1'b1;
    data_in  = 32'hDEADBEEF;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b, required 1", ready_out);
    end
    step();
    valid_in = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_hold: got %b, required 1", busy);
    end
    wait_cyc(72);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_last_bit: got %b, required 1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: got %b, required 0", busy);
    end
    wait_cyc(81);
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (lane0_slot[4 + s] !== exp0[s] || lane1_slot[4 + s] !== 8'hBC) begin
        errors++;
        $display("FAIL single slot %0d: got %h/%h, required %h/bc",
                 4 + s, lane0_slot[4 + s], lane1_slot[4 + s], exp0[s]);
      end
    end
  endtask

  task automatic test_boundary_accept();
    logic [7:0] exp1 [6];
    exp1 = '{8'hBC, 8'h3C, 8'h5A, 8'h96, 8'h12, 8'hBC};
    wait_cyc(88);
    valid_in = 1'b1;
    data_in  = 32'h3C5A9612;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL boundary_ready: got %b, required 1", ready_out);
    end
    step();
    valid_in = 1'b0;
    wait_cyc(137);
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (lane0_slot[11 + s] !== 8'hBC || lane1_slot[11 + s] !== exp1[s]) begin
        errors++;
        $display("FAIL boundary slot %0d: got %h/%h, required bc/%h",
                 11 + s, lane0_slot[11 + s], lane1_slot[11 + s], exp1[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp0 [6];
    logic [7:0] exp1 [6];
    exp0 = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'h04, 8'hBC};
    exp1 = '{8'hBC, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'hBC};
    wait_cyc(138);
    valid_in = 1'b1;
    data_in  = 32'h01020304;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_first: got %b, required 1", ready_out);
    end
    step();
    data_in = 32'hA5A55A5A;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_second: got %b, required 1", ready_out);
    end
    step();
    valid_in = 1'b0;
    checks++;
    if ({ready_out, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_after: ready/busy %b, required 01", {ready_out, busy});
    end
    wait_cyc(185);
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (lane0_slot[17 + s] !== exp0[s] || lane1_slot[17 + s] !== exp1[s]) begin
        errors++;
        $display("FAIL b2b slot %0d: got %h/%h, required %h/%h",
                 17 + s, lane0_slot[17 + s], lane1_slot[17 + s], exp0[s], exp1[s]);
      end
    end
  endtask

  task automatic test_stream();
    int exp_acc [6];
    int acc [6];
    int i = 0;
    int n = 0;
    logic [7:0] e0;
    logic [7:0] e1;
    exp_acc = '{193, 194, 226, 227, 258, 259};
    wait_cyc(192);
    while (i < 6 && n < 200) begin
      valid_in = 1'b1;
      data_in  = 32'(i + 1);
      if (ready_out === 1'b1) begin
        acc[i] = cyc + 1;
        i++;
      end
      step();
      n++;
    end
    valid_in = 1'b0;
    checks++;
    if (i != 6) begin
      errors++;
      $display("FAIL stream_count: accepted %0d words, required 6", i);
    end
    for (int k = 0; k < i; k++) begin
      checks++;
      if (acc[k] != exp_acc[k]) begin
        errors++;
        $display("FAIL stream_accept word %0d: edge %0d, required %0d", k + 1, acc[k], exp_acc[k]);
      end
    end
    wait_cyc(305);
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 4; b++) begin
        e0 = (b == 3) ? 8'(2 * k + 1) : 8'h00;
        e1 = (b == 3) ? 8'(2 * k + 2) : 8'h00;
        checks++;
        if (lane0_slot[25 + 4 * k + b] !== e0 || lane1_slot[25 + 4 * k + b] !== e1) begin
          errors++;
          $display("FAIL stream slot %0d: got %h/%h, required %h/%h", 25 + 4 * k + b,
                   lane0_slot[25 + 4 * k + b], lane1_slot[25 + 4 * k + b], e0, e1);
        end
      end
    end
    checks++;
    if (lane0_slot[37] !== 8'hBC || lane1_slot[37] !== 8'hBC) begin
      errors++;
      $display("FAIL stream_idle: got %h/%h, required bc/bc", lane0_slot[37], lane1_slot[37]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp0 [9];
    exp0 = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h12, 8'h34, 8'h56, 8'h78, 8'hBC};
    wait_cyc(306);
    valid_in = 1'b1;
    data_in  = 32'hCAFEF00D;
    step();
    valid_in = 1'b0;
    wait_cyc(313);
    checks++;
    if (data_out0 !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_ca_msb: out0/busy %b%b, required 11", data_out0, busy);
    end
    wait_cyc(315);
    reset_L = 1'b0;
    step();
    checks++;
    if ({data_out0, data_out1, ready_out, align_done, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b, required 00000",
               {data_out0, data_out1, ready_out, align_done, busy});
    end
    step();
    step();
    reset_L = 1'b1;
    wait_cyc(24);
    checks++;
    if ({align_done, ready_out, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_realign_early: got %b, required 000", {align_done, ready_out, busy});
    end
    wait_cyc(25);
    checks++;
    if ({align_done, ready_out} !== 2'b11) begin
      errors++;
      $display("FAIL mid_realign_done: got %b, required 11", {align_done, ready_out});
    end
    valid_in = 1'b1;
    data_in  = 32'h12345678;
    step();
    valid_in = 1'b0;
    wait_cyc(73);
    for (int s = 0; s < 9; s++) begin
      checks++;
      if (lane0_slot[s] !== exp0[s] || lane1_slot[s] !== 8'hBC) begin
        errors++;
        $display("FAIL mid slot %0d: got %h/%h, required %h/bc", s, lane0_slot[s], lane1_slot[s], exp0[s]);
      end
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    test_reset();
    test_single();
    test_boundary_accept();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
